// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, requests IMEM at PC and registers the returned word.
// Latency: one edge from ack to Instr_valid; IMEM_req stays high until acked, and a PC load drops any in-flight data.
module if_fetch_unit (
    input  logic        Clk,
    input  logic        reset,
    input  logic        PC_LdEn,
    input  logic        b,
    input  logic        beq,
    input  logic        bne,
    input  logic        Zero,
    input  logic [15:0] Imm16,
    output logic        IMEM_req,
    output logic [31:0] IMEM_addr,
    input  logic        IMEM_ack,
    input  logic [31:0] IMEM_rdata,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic        Instr_valid
);

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    logic        taken;
    logic [31:0] br_off;
    logic [31:0] pc_next;

    assign taken   = b | (beq & Zero) | (bne & ~Zero);
    assign br_off  = {{14{Imm16[15]}}, Imm16, 2'b00};
    assign pc_next = pc_q + 32'd4 + (taken ? br_off : 32'd0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        // A PC load always wins: whatever the memory returns this cycle belongs to the old PC.
        if (PC_LdEn) begin
            pc_d    = pc_next;
            state_d = FETCH;
        end else if (state_q == FETCH && IMEM_ack) begin
            instr_d = IMEM_rdata;
            state_d = VALID;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= 32'h0000_0000;
            instr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign IMEM_req    = (state_q == FETCH);
    assign IMEM_addr   = pc_q;
    assign PC          = pc_q;
    assign Instr       = instr_q;
    assign Instr_valid = (state_q == VALID);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: inputs change and outputs are sampled on the falling edge.
module tb_if_fetch_unit;

    logic        Clk;
    logic        reset;
    logic        PC_LdEn;
    logic        b, beq, bne, Zero;
    logic [15:0] Imm16;
    logic        IMEM_req;
    logic [31:0] IMEM_addr;
    logic        IMEM_ack;
    logic [31:0] IMEM_rdata;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        Instr_valid;

    int checks = 0;
    int errors = 0;

    if_fetch_unit dut (
        .Clk        (Clk),
        .reset      (reset),
        .PC_LdEn    (PC_LdEn),
        .b          (b),
        .beq        (beq),
        .bne        (bne),
        .Zero       (Zero),
        .Imm16      (Imm16),
        .IMEM_req   (IMEM_req),
        .IMEM_addr  (IMEM_addr),
        .IMEM_ack   (IMEM_ack),
        .IMEM_rdata (IMEM_rdata),
        .PC         (PC),
        .Instr      (Instr),
        .Instr_valid(Instr_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    // One PC_LdEn pulse with the given branch controls, then return the controls to idle.
    task automatic ld(input logic ib, input logic ibeq, input logic ibne,
                      input logic iz, input logic [15:0] imm);
        PC_LdEn = 1'b1; b = ib; beq = ibeq; bne = ibne; Zero = iz; Imm16 = imm;
        step();
        PC_LdEn = 1'b0; b = 1'b0; beq = 1'b0; bne = 1'b0; Zero = 1'b0; Imm16 = 16'h0;
    endtask

    initial begin
        reset = 1'b1; PC_LdEn = 1'b0; b = 1'b0; beq = 1'b0; bne = 1'b0; Zero = 1'b0;
        Imm16 = 16'h0; IMEM_ack = 1'b1; IMEM_rdata = 32'h8000_0000;

        // Reset held across edges with ack high: data must be dropped.
        step(); step();
        check("rst_pc",    PC,          32'h0);
        check("rst_instr", Instr,       32'h0);
        check("rst_valid", {31'b0, Instr_valid}, 32'd0);
        check("rst_req",   {31'b0, IMEM_req},    32'd1);

        reset = 1'b0;
        step();
        check("first_addr",  IMEM_addr,   32'h0);
        check("first_instr", Instr,       32'h8000_0000);
        check("first_valid", {31'b0, Instr_valid}, 32'd1);
        check("first_req",   {31'b0, IMEM_req},    32'd0);
        IMEM_ack = 1'b0;

        // Jump to 0x10 and fetch there.
        ld(1, 0, 0, 0, 16'd3);
        check("jmp10_pc", PC, 32'h10);
        IMEM_ack = 1'b1; IMEM_rdata = 32'h1111_1111;
        step();
        IMEM_ack = 1'b0;
        check("f10_instr", Instr, 32'h1111_1111);
        check("f10_valid", {31'b0, Instr_valid}, 32'd1);

        // Sequential advance from VALID.
        ld(0, 0, 0, 0, 16'h0);
        check("seq_pc",    PC,    32'h14);
        check("seq_valid", {31'b0, Instr_valid}, 32'd0);
        check("seq_req",   {31'b0, IMEM_req},    32'd1);
        check("seq_instr_kept", Instr, 32'h1111_1111);

        ld(1, 0, 0, 0, 16'd2);
        check("to20_pc", PC, 32'h20);
        ld(0, 1, 0, 1, 16'hFFFE);
        check("beq_taken", PC, 32'h1C);
        ld(1, 0, 0, 0, 16'h0);
        check("back20_a", PC, 32'h20);
        ld(0, 1, 0, 0, 16'hFFFE);
        check("beq_not", PC, 32'h24);
        ld(1, 0, 0, 0, 16'hFFFE);
        check("back20_b", PC, 32'h20);
        ld(0, 0, 1, 0, 16'h0003);
        check("bne_taken", PC, 32'h30);
        ld(0, 0, 1, 1, 16'h0003);
        check("bne_not", PC, 32'h34);
        ld(0, 1, 1, 1, 16'h0001);
        check("multi_or", PC, 32'h3C);

        // Branch inputs without PC_LdEn have no effect.
        b = 1'b1; beq = 1'b1; Zero = 1'b1; Imm16 = 16'h0100;
        step();
        b = 1'b0; beq = 1'b0; Zero = 1'b0; Imm16 = 16'h0;
        check("no_ld_hold", PC, 32'h3C);

        ld(1, 0, 0, 0, 16'hFFEF);
        check("to_top", PC, 32'hFFFF_FFFC);
        ld(0, 0, 0, 0, 16'h0);
        check("wrap_up", PC, 32'h0);
        ld(1, 0, 0, 0, 16'hFFFE);
        check("wrap_down", PC, 32'hFFFF_FFFC);
        ld(0, 0, 0, 0, 16'h0);
        check("wrap_up2", PC, 32'h0);

        // Slow memory: five idle cycles then ack.
        for (int i = 0; i < 5; i++) begin
            step();
            check("wait_req",   {31'b0, IMEM_req},    32'd1);
            check("wait_valid", {31'b0, Instr_valid}, 32'd0);
        end
        IMEM_ack = 1'b1; IMEM_rdata = 32'hA5A5_A5A5;
        step();
        IMEM_ack = 1'b0;
        check("slow_instr", Instr, 32'hA5A5_A5A5);
        check("slow_valid", {31'b0, Instr_valid}, 32'd1);

        // Ack coinciding with a PC load is discarded.
        ld(0, 0, 0, 0, 16'h0);
        step();
        IMEM_ack = 1'b1; IMEM_rdata = 32'hDEAD_BEEF;
        ld(0, 0, 0, 0, 16'h0);
        IMEM_ack = 1'b0;
        check("disc_pc",    IMEM_addr, 32'h8);
        check("disc_instr", Instr,     32'hA5A5_A5A5);
        check("disc_valid", {31'b0, Instr_valid}, 32'd0);
        check("disc_req",   {31'b0, IMEM_req},    32'd1);
        IMEM_ack = 1'b1; IMEM_rdata = 32'h1234_5678;
        step();
        check("refetch_instr", Instr, 32'h1234_5678);
        check("refetch_valid", {31'b0, Instr_valid}, 32'd1);

        // VALID holds even with a stray ack.
        IMEM_rdata = 32'h0BAD_0BAD;
        step(); step();
        IMEM_ack = 1'b0;
        check("hold_instr", Instr, 32'h1234_5678);
        check("hold_pc",    PC,    32'h8);
        check("hold_valid", {31'b0, Instr_valid}, 32'd1);

        // Asynchronous reset in the middle of a wait.
        ld(0, 0, 0, 0, 16'h0);
        step();
        #2 reset = 1'b1;
        #1;
        check("arst_pc",    PC,    32'h0);
        check("arst_instr", Instr, 32'h0);
        check("arst_valid", {31'b0, Instr_valid}, 32'd0);
        check("arst_req",   {31'b0, IMEM_req},    32'd1);
        IMEM_ack = 1'b1; IMEM_rdata = 32'hFFFF_0000;
        step();
        check("arst_ack_drop", Instr, 32'h0);
        IMEM_ack = 1'b0;
        reset = 1'b0;
        step();
        check("post_rst_valid", {31'b0, Instr_valid}, 32'd0);
        check("post_rst_pc",    PC, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
